// File: rtl/network_pkg.sv
// Shared types and helpers for the sample-rate conv network sequencer.
//   seq_state_e : sequencer FSM states
//   OVERRUN_W   : width of the saturating overrun counter
//   lane_lsb()  : bit offset of a lane in a packed layer output (lane 0 in the top bits)
//   sat_shift() : arithmetic left shift of a sign-extended value, clamped to a w-bit signed range
package network_pkg;

  localparam int unsigned OVERRUN_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStepLsb,
    StStart,
    StWait,
    StStepCache,
    StLatch
  } seq_state_e;

  // Lane 0 sits in the most significant W bits of the packed bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned d,
                                           input int unsigned w);
    return (d - 1 - lane) * w;
  endfunction

  // value must already be sign-extended to 64 bits; w <= 32 and shift < 32 keep the
  // intermediate product exact, so the clamp sees the true mathematical result.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int unsigned shift,
                                                   input int unsigned w);
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted = value <<< shift;
    max_v   = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (w - 1));
    if (shifted > max_v) begin
      return max_v;
    end else if (shifted < min_v) begin
      return min_v;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/output_saturator.sv
// Combinational output scaling: takes the top N_OUT lanes of the last layer's packed output,
// shifts each left by OUT_SHIFT and clamps it to the signed W-bit range.
//   layer_out : D*W packed lanes, lane 0 in bits [D*W-1:(D-1)*W]
//   sat_out   : N_OUT*W packed channels, channel 0 in the top W bits
module output_saturator
  import network_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned D         = 8,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned OUT_SHIFT = 2
) (
  input  logic [D*W-1:0]     layer_out,
  output logic [N_OUT*W-1:0] sat_out
);

  for (genvar c = 0; c < N_OUT; c++) begin : g_lane
    localparam int unsigned InLsb  = lane_lsb(c, D, W);
    localparam int unsigned OutLsb = (N_OUT - 1 - c) * W;

    logic [W-1:0]       lane;
    logic signed [63:0] lane_ext;

    assign lane     = layer_out[InLsb +: W];
    assign lane_ext = {{(64 - W){lane[W-1]}}, lane};
    assign sat_out[OutLsb +: W] = W'(sat_shift(lane_ext, OUT_SHIFT, W));
  end

  // Lanes below the output channels are not part of the sample.
  if (N_OUT < D) begin : g_unused
    logic unused_low_lanes;
    assign unused_low_lanes = ^layer_out[(D - N_OUT)*W-1:0];
  end

endmodule

// File: rtl/network_sequencer.sv
// Control core for the sample-rate conv network. On each rising edge of sample_clk it steps
// the input shift buffer, then starts each conv layer in turn and waits for its done (stepping
// the activation cache between layers), and finally latches the last layer's outputs as
// saturated, gain-shifted samples.
//   clk, rst     : system clock, synchronous active-high reset
//   sample_clk   : sample strobe (synchronous to clk)
//   layer_done   : per-layer done from conv1d
//   layer_out    : packed output of the last layer, lane 0 in the top W bits
//   lsb_step     : one-cycle pulse to the input shift buffer
//   layer_start  : one-hot one-cycle start pulse per layer
//   cache_step   : one-cycle pulse to activation cache i after layer i
//   sample_out   : N_OUT saturated channels, channel 0 in the top W bits
//   out_valid    : one-cycle pulse when sample_out updates
//   busy         : sequence in progress
//   overrun_cnt  : saturating count of edges ignored while busy
//   timeout_err  : sticky, a layer exceeded MAX_LAYER_CYCLES wait cycles
module network_sequencer
  import network_pkg::*;
#(
  parameter int unsigned W                = 16,
  parameter int unsigned D                = 8,
  parameter int unsigned NUM_LAYERS       = 2,
  parameter int unsigned N_OUT            = 4,
  parameter int unsigned OUT_SHIFT        = 2,
  parameter int unsigned MAX_LAYER_CYCLES = 1024,
  localparam int unsigned CACHE_W         = (NUM_LAYERS > 1) ? NUM_LAYERS - 1 : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clk,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [D*W-1:0]        layer_out,
  output logic                  lsb_step,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [CACHE_W-1:0]    cache_step,
  output logic [N_OUT*W-1:0]    sample_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [OVERRUN_W-1:0]  overrun_cnt,
  output logic                  timeout_err
);

  localparam int unsigned LI_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned CNT_W = (MAX_LAYER_CYCLES > 1) ? $clog2(MAX_LAYER_CYCLES) : 1;
  localparam logic [LI_W-1:0]  LastLi  = LI_W'(NUM_LAYERS - 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_LAYER_CYCLES - 1);

  seq_state_e           state_q, state_d;
  logic [LI_W-1:0]      li_q, li_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 prev_sample_clk_q, prev_sample_clk_d;
  logic [N_OUT*W-1:0]   sample_out_q, sample_out_d;
  logic                 out_valid_q, out_valid_d;
  logic [OVERRUN_W-1:0] overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;

  logic                 sample_edge;
  logic                 done_sel;
  logic [N_OUT*W-1:0]   sat_sample;

  output_saturator #(
    .W        (W),
    .D        (D),
    .N_OUT    (N_OUT),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_output_saturator (
    .layer_out(layer_out),
    .sat_out  (sat_sample)
  );

  assign sample_edge = sample_clk & ~prev_sample_clk_q;
  assign done_sel    = |(layer_done & (NUM_LAYERS'(1) << li_q));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      li_q              <= '0;
      cnt_q             <= '0;
      // Starting high means a strobe held high through reset is not taken as an edge.
      prev_sample_clk_q <= 1'b1;
      sample_out_q      <= '0;
      out_valid_q       <= 1'b0;
      overrun_q         <= '0;
      timeout_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      li_q              <= li_d;
      cnt_q             <= cnt_d;
      prev_sample_clk_q <= prev_sample_clk_d;
      sample_out_q      <= sample_out_d;
      out_valid_q       <= out_valid_d;
      overrun_q         <= overrun_d;
      timeout_q         <= timeout_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d           = state_q;
    li_d              = li_q;
    cnt_d             = cnt_q;
    prev_sample_clk_d = sample_clk;
    sample_out_d      = sample_out_q;
    out_valid_d       = 1'b0;
    overrun_d         = overrun_q;
    timeout_d         = timeout_q;

    // Any edge seen outside IDLE is dropped, including the cycle the FSM heads back to IDLE.
    if (sample_edge && (state_q != StIdle) && (overrun_q != '1)) begin
      overrun_d = overrun_q + OVERRUN_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (sample_edge) begin
          state_d = StStepLsb;
          li_d    = '0;
        end
      end
      StStepLsb: begin
        state_d = StStart;
      end
      StStart: begin
        // layer_done may still hold the previous sample's value here, so it is not looked at.
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (done_sel) begin
          state_d = (li_q != LastLi) ? StStepCache : StLatch;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStepCache: begin
        li_d    = li_q + LI_W'(1);
        state_d = StStart;
      end
      StLatch: begin
        sample_out_d = sat_sample;
        out_valid_d  = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore output decode
  always_comb begin
    lsb_step    = (state_q == StStepLsb);
    layer_start = (state_q == StStart) ? (NUM_LAYERS'(1) << li_q) : '0;
    busy        = (state_q != StIdle);
  end

  if (NUM_LAYERS > 1) begin : g_cache_step
    always_comb begin
      cache_step = (state_q == StStepCache) ? (CACHE_W'(1) << li_q) : '0;
    end
  end else begin : g_no_cache_step
    assign cache_step = '0;
  end

  assign sample_out  = sample_out_q;
  assign out_valid   = out_valid_q;
  assign overrun_cnt = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_network_sequencer.sv
module tb_network_sequencer;

  localparam int W         = 16;
  localparam int D         = 8;
  localparam int L         = 2;
  localparam int N_OUT     = 4;
  localparam int OUT_SHIFT = 2;
  localparam int MAXC      = 1024;
  localparam int CW        = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_clk;
  logic [L-1:0]       layer_done;
  logic [D*W-1:0]     layer_out;
  logic               lsb_step;
  logic [L-1:0]       layer_start;
  logic [CW-1:0]      cache_step;
  logic [N_OUT*W-1:0] sample_out;
  logic               out_valid;
  logic               busy;
  logic [7:0]         overrun_cnt;
  logic               timeout_err;

  always #5 clk = ~clk;

  network_sequencer #(
    .W               (W),
    .D               (D),
    .NUM_LAYERS      (L),
    .N_OUT           (N_OUT),
    .OUT_SHIFT       (OUT_SHIFT),
    .MAX_LAYER_CYCLES(MAXC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .layer_done (layer_done),
    .layer_out  (layer_out),
    .lsb_step   (lsb_step),
    .layer_start(layer_start),
    .cache_step (cache_step),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: a sequence is a schedule of event cycles relative to the accepted edge.
  bit                 m_active    = 1'b0;
  int                 m_lsb_t     = -1;
  int                 m_start_t   = -1;
  int                 m_wait_from = -1;
  int                 m_layer     = 0;
  int                 m_cache_t   = -1;
  int                 m_cache_idx = 0;
  int                 m_latch_t   = -1;
  int                 m_ov_t      = -1;
  bit                 m_resolved  = 1'b0;
  logic [N_OUT*W-1:0] m_sample    = '0;
  bit                 m_timeout   = 1'b0;
  int                 m_overrun   = 0;
  bit                 m_prev      = 1'b1;

  int n_lsb = 0, n_start0 = 0, n_start1 = 0, n_cache0 = 0, n_ov = 0;
  int last_ov_cyc = -1;

  function automatic logic [W-1:0] m_sat(input logic [W-1:0] lane);
    longint v, hi, lo;
    v  = longint'($signed(lane)) * (longint'(1) << OUT_SHIFT);
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    bit e;
    int t;
    t = cyc;
    if (rst) begin
      m_active  = 1'b0;
      m_ov_t    = -1;
      m_sample  = '0;
      m_timeout = 1'b0;
      m_overrun = 0;
      m_prev    = 1'b1;
    end else begin
      e      = sample_clk && !m_prev;
      m_prev = sample_clk;
      if (m_active) begin
        if (e && m_overrun < 255) m_overrun++;
        if (t == m_latch_t) begin
          for (int c = 0; c < N_OUT; c++)
            m_sample[N_OUT*W-1-c*W -: W] = m_sat(layer_out[D*W-1-c*W -: W]);
          m_ov_t   = t + 1;
          m_active = 1'b0;
        end else if (!m_resolved && t >= m_wait_from) begin
          if (layer_done[m_layer]) begin
            if (m_layer < L - 1) begin
              m_cache_t   = t + 1;
              m_cache_idx = m_layer;
              m_layer++;
              m_start_t   = t + 2;
              m_wait_from = t + 3;
            end else begin
              m_latch_t  = t + 1;
              m_resolved = 1'b1;
            end
          end else if (t - m_wait_from == MAXC - 1) begin
            m_timeout = 1'b1;
            m_active  = 1'b0;
          end
        end
      end else if (e) begin
        m_active    = 1'b1;
        m_lsb_t     = t + 1;
        m_start_t   = t + 2;
        m_wait_from = t + 3;
        m_layer     = 0;
        m_resolved  = 1'b0;
        m_latch_t   = -1;
        m_cache_t   = -1;
      end
    end
  endtask

  // One clock: compare every output against the model, advance the model, drive next cycle.
  task automatic tick();
    logic [L-1:0]  exp_ls;
    logic [CW-1:0] exp_cs;
    @(negedge clk);
    exp_ls = (m_active && cyc == m_start_t) ? (L'(1) << m_layer) : '0;
    exp_cs = (m_active && cyc == m_cache_t) ? (CW'(1) << m_cache_idx) : '0;
    chk("busy", 64'(busy), 64'(m_active));
    chk("lsb_step", 64'(lsb_step), 64'(m_active && cyc == m_lsb_t));
    chk("layer_start", 64'(layer_start), 64'(exp_ls));
    chk("cache_step", 64'(cache_step), 64'(exp_cs));
    chk("out_valid", 64'(out_valid), 64'(cyc == m_ov_t));
    chk("sample_out", 64'(sample_out), 64'(m_sample));
    chk("timeout_err", 64'(timeout_err), 64'(m_timeout));
    chk("overrun_cnt", 64'(overrun_cnt), 64'(m_overrun));
    if (lsb_step) n_lsb++;
    if (layer_start[0]) n_start0++;
    if (layer_start[1]) n_start1++;
    if (cache_step[0]) n_cache0++;
    if (out_valid) begin
      n_ov++;
      last_ov_cyc = cyc;
    end
    model_update();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_edge(output int e);
    sample_clk = 1'b0;
    tick();
    sample_clk = 1'b1;
    e = cyc;
    tick();
    sample_clk = 1'b0;
  endtask

  initial begin
    int e, s_lsb, s_st0, s_st1, s_c0, s_ov;
    rst        = 1'b1;
    sample_clk = 1'b0;
    layer_done = '0;
    layer_out  = '0;
    ticks(3);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_sample_out", 64'(sample_out), 64'(0));
    rst = 1'b0;
    ticks(2);

    // Single sequence, done on first WAIT cycle of each layer.
    layer_done = 2'b11;
    layer_out  = {16'h0100, 112'h0};
    s_lsb = n_lsb; s_st0 = n_start0; s_st1 = n_start1; s_c0 = n_cache0;
    last_ov_cyc = -1;
    do_edge(e);
    ticks(12);
    chk("t1_latency", 64'(last_ov_cyc - e), 64'(8));
    chk("t1_ch0", 64'(sample_out[63:48]), 64'(16'h0400));
    chk("t1_lsb_pulses", 64'(n_lsb - s_lsb), 64'(1));
    chk("t1_start0_pulses", 64'(n_start0 - s_st0), 64'(1));
    chk("t1_cache0_pulses", 64'(n_cache0 - s_c0), 64'(1));
    chk("t1_start1_pulses", 64'(n_start1 - s_st1), 64'(1));

    // Saturation of positive and negative lanes.
    layer_out = {16'h2000, 16'hD000, 16'h1FFF, 16'hE000, 64'h0};
    do_edge(e);
    ticks(12);
    chk("t2_saturation", 64'(sample_out), 64'h7FFF_8000_7FFC_8000);

    // Layer 1 never finishes: timeout after MAXC wait cycles.
    layer_done = 2'b01;
    layer_out  = {8{16'h0001}};
    s_ov = n_ov;
    do_edge(e);
    while (cyc < e + 5 + MAXC) tick();
    chk("t3_busy_last_wait", 64'(busy), 64'(1));
    tick();
    chk("t3_idle_after_timeout", 64'(busy), 64'(0));
    chk("t3_timeout_err", 64'(timeout_err), 64'(1));
    chk("t3_sample_kept", 64'(sample_out), 64'h7FFF_8000_7FFC_8000);
    chk("t3_no_out_valid", 64'(n_ov - s_ov), 64'(0));
    layer_done = 2'b11;
    layer_out  = {16'h0100, 112'h0};
    last_ov_cyc = -1;
    do_edge(e);
    ticks(12);
    chk("t3_recover_latency", 64'(last_ov_cyc - e), 64'(8));
    chk("t3_recover_ch0", 64'(sample_out[63:48]), 64'(16'h0400));

    // Edges while held in WAIT0 are counted, never restart.
    layer_done = 2'b00;
    s_st0 = n_start0;
    do_edge(e);
    ticks(3);
    for (int i = 0; i < 300; i++) do_edge(e);
    chk("t4_overrun_sat", 64'(overrun_cnt), 64'(255));
    chk("t4_one_start0", 64'(n_start0 - s_st0), 64'(1));

    // Move on to WAIT1, then reset mid-sequence.
    layer_done = 2'b01;
    ticks(4);
    chk("t5_busy_in_wait1", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_pulses", 64'({lsb_step, layer_start, cache_step, out_valid}), 64'(0));
    chk("t5_sample_out", 64'(sample_out), 64'(0));
    chk("t5_overrun", 64'(overrun_cnt), 64'(0));

    // sample_clk high through reset release is not an edge.
    sample_clk = 1'b1;
    layer_done = 2'b11;
    ticks(2);
    rst = 1'b0;
    s_lsb = n_lsb;
    ticks(5);
    chk("t6_no_edge_high", 64'(n_lsb - s_lsb), 64'(0));
    do_edge(e);
    ticks(12);
    chk("t6_edge_after_low", 64'(n_lsb - s_lsb), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/network_sequencer.md
Name: network_sequencer

Overview:
- Generalised control core for the sample-rate conv network: detects each rising edge of `sample_clk`, then runs a fixed sequence.
- Sequence: step the input shift buffer; for each of NUM_LAYERS conv layers, start it and wait for its done, stepping the inter-layer activation cache after every layer but the last; finally latch the last layer's outputs into saturated, gain-shifted samples.
- Adds layer-count parameterisation, per-layer timeout, overrun counting and saturating output scaling.
- Sits between the codec sample strobe and the conv1d / activation_cache / left_shift_buffer instances.

Parameters:
- W, 16, sample / lane width in bits
- D, 8, lanes per packed layer output
- NUM_LAYERS, 2, number of conv layers sequenced (>=1)
- N_OUT, 4, output channels taken from the top lanes of the last layer (<=D)
- OUT_SHIFT, 2, arithmetic left shift applied to each output lane before saturation
- MAX_LAYER_CYCLES, 1024, WAIT cycles allowed per layer before timeout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_clk  in  1  sample strobe, already synchronous to clk
- layer_done  in  NUM_LAYERS  per-layer out_v from conv1d
- layer_out  in  D*W  packed output of last layer; lane 0 = bits [D*W-1:(D-1)*W]
- lsb_step  out  1  one-cycle pulse clocking the input shift buffer
- layer_start  out  NUM_LAYERS  one-hot one-cycle start/reset pulse per layer
- cache_step  out  max(NUM_LAYERS-1,1)  one-cycle pulse clocking activation cache i after layer i
- sample_out  out  N_OUT*W  channel c = saturated lane c; channel 0 in the top W bits
- out_valid  out  1  one-cycle pulse when sample_out updates
- busy  out  1  high whenever state != IDLE
- overrun_cnt  out  8  saturating count of sample edges ignored while busy
- timeout_err  out  1  sticky flag; cleared only by rst

Behaviour:
- Reset values: state IDLE; all pulses 0; sample_out 0; overrun_cnt 0; timeout_err 0.
- `prev_sample_clk` resets to 1, so a `sample_clk` held high through reset is not an edge.
- Edge definition: `sample_clk`=1 and `prev_sample_clk`=0 in the same cycle.
- States: IDLE, STEP_LSB, START, WAIT, STEP_CACHE, LATCH. Layer index `li` ranges 0..NUM_LAYERS-1.
- Outputs are Moore decodes of state, so every pulse is exactly one cycle wide:
  - lsb_step = STEP_LSB
  - layer_start[li] = START
  - cache_step[li] = STEP_CACHE
  - out_valid is registered and high in the cycle after LATCH
- IDLE: on edge -> STEP_LSB, li=0.
- STEP_LSB -> START.
- START -> WAIT; clear the timeout counter. `layer_done` is ignored in the START cycle because it may be stale.
- WAIT:
  - if layer_done[li]: go to STEP_CACHE when li<NUM_LAYERS-1, else LATCH;
  - else if counter == MAX_LAYER_CYCLES-1: set timeout_err, go to IDLE, leave sample_out unchanged;
  - else increment counter.
- STEP_CACHE: li++ -> START.
- LATCH: for each c, sample_out[c] <= sat(sign_extend(lane c) <<< OUT_SHIFT), clamped to [-2^(W-1), 2^(W-1)-1]. Then -> IDLE.
- Minimum latency with NUM_LAYERS=2, done arriving on the first WAIT cycle:
  - edge at cycle E
  - STEP_LSB at E+1, START0 at E+2, WAIT0 at E+3, STEP_CACHE0 at E+4, START1 at E+5, WAIT1 at E+6, LATCH at E+7
  - out_valid and new sample_out at E+8
- Overrun: an edge while busy (including the LATCH cycle) never restarts the sequence; overrun_cnt increments and saturates at 255.
- An edge in the same cycle the FSM returns from LATCH or timeout to IDLE counts as overrun; the edge is consumed.
- rst mid-sequence: next cycle is IDLE with all pulses low; a layer in progress is restarted by its next START.
- NUM_LAYERS=1: STEP_CACHE is never entered; cache_step is tied to 0.

Decomposition:
- Package `network_pkg`:
  - state enum typedef
  - `sat_shift(value, shift)` function parameterised on W
  - lane-extract helper
  - OVERRUN_W=8 constant
- One sub-module `output_saturator`: N_OUT parallel shift-and-clamp lanes, combinational, registered in the parent.

Test Plan:
- Single edge, NUM_LAYERS=2, done on the first WAIT cycle, lane0=0x0100 -> out_valid at E+8, sample_out[0]=0x0400; one pulse each of lsb_step, layer_start[0], cache_step[0], layer_start[1].
- Saturation: lane0=0x2000, lane1=0xD000, lane2=0x1FFF, lane3=0xE000 -> 0x7FFF, 0x8000, 0x7FFC, 0x8000.
- layer_done[1] never asserts, MAX_LAYER_CYCLES=16 -> FSM back in IDLE 16 WAIT cycles after START1; timeout_err=1; sample_out unchanged; no out_valid; next edge sequences normally.
- 300 edges while the FSM is held in WAIT (done low, large timeout) -> overrun_cnt=255, exactly one layer_start[0] pulse.
- sample_clk high before and through rst release -> no lsb_step until sample_clk goes low then high.
- rst asserted in WAIT1 -> next cycle busy=0, all pulses 0, sample_out=0, overrun_cnt=0.
